sd_blk_resp: RTL and testbench

SD_BLK_RESP -- requirements
Module: sd_blk_resp

---
 rtl/sd_blk_resp.sv | 171 +++++++++++++++++
 tb/tb_sd_blk_resp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_blk_resp.sv
`timescale 1ns/1ps
// SD block responder: moves one 512-byte block between the core sector buffer and a byte-wide backing store.
// Latency: sd_ack rises ACK_DELAY cycles after acceptance; store_rd/store_wr are held until store_ready (backpressure stalls the byte walk).
module sd_blk_resp #(
  parameter int LBA_W     = 8,
  parameter int ACK_DELAY = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [31:0]      sd_lba,
  input  logic             sd_rd,
  input  logic             sd_wr,
  output logic             sd_ack,
  output logic [8:0]       sd_buff_addr,
  output logic [7:0]       sd_buff_dout,
  output logic             sd_buff_wr,
  input  logic [7:0]       sd_buff_din,
  output logic [LBA_W+8:0] store_addr,
  output logic             store_rd,
  output logic             store_wr,
  output logic [7:0]       store_din,
  input  logic [7:0]       store_dout,
  input  logic             store_ready
);

  typedef enum logic [2:0] {
    IDLE, DELAY, RD_REQ, RD_PUT, WR_ADDR, WR_WAIT, WR_REQ, DONE
  } state_t;

  localparam logic [3:0] DLY_LAST  = 4'(ACK_DELAY - 1);
  localparam logic [8:0] BYTE_LAST = 9'd511;

  state_t             state_q, state_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic               is_rd_q, is_rd_d;
  logic [8:0]         byte_q, byte_d;
  logic [3:0]         dly_q, dly_d;
  logic               sd_ack_q, sd_ack_d;
  logic [8:0]         sd_buff_addr_q, sd_buff_addr_d;
  logic [7:0]         sd_buff_dout_q, sd_buff_dout_d;
  logic               sd_buff_wr_q, sd_buff_wr_d;
  logic               store_rd_q, store_rd_d;
  logic               store_wr_q, store_wr_d;
  logic [7:0]         store_din_q, store_din_d;
  logic [LBA_W+8:0]   store_addr_q, store_addr_d;

  logic lba_hi_unused;
  assign lba_hi_unused = ^sd_lba[31:LBA_W];

  always_comb begin
    state_d        = state_q;
    lba_d          = lba_q;
    is_rd_d        = is_rd_q;
    byte_d         = byte_q;
    dly_d          = dly_q;
    sd_ack_d       = sd_ack_q;
    sd_buff_dout_d = sd_buff_dout_q;
    sd_buff_wr_d   = 1'b0;
    store_rd_d     = store_rd_q;
    store_wr_d     = store_wr_q;
    store_din_d    = store_din_q;

    case (state_q)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d   = sd_lba[LBA_W-1:0];
          is_rd_d = sd_rd;
          byte_d  = 9'd0;
          dly_d   = 4'd0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (dly_q == DLY_LAST) begin
          sd_ack_d   = 1'b1;
          store_rd_d = is_rd_q;
          state_d    = is_rd_q ? RD_REQ : WR_ADDR;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      RD_REQ: begin
        if (store_ready) begin
          sd_buff_dout_d = store_dout;
          store_rd_d     = 1'b0;
          sd_buff_wr_d   = 1'b1;
          state_d        = RD_PUT;
        end
      end
      RD_PUT: begin
        if (byte_q == BYTE_LAST) begin
          sd_ack_d = 1'b0;
          byte_d   = 9'd0;
          state_d  = DONE;
        end else begin
          byte_d     = byte_q + 9'd1;
          store_rd_d = 1'b1;
          state_d    = RD_REQ;
        end
      end
      WR_ADDR: state_d = WR_WAIT;
      // Buffer RAM output is registered, so data for byte_q is valid only now.
      WR_WAIT: begin
        store_din_d = sd_buff_din;
        store_wr_d  = 1'b1;
        state_d     = WR_REQ;
      end
      WR_REQ: begin
        if (store_ready) begin
          store_wr_d = 1'b0;
          if (byte_q == BYTE_LAST) begin
            sd_ack_d = 1'b0;
            byte_d   = 9'd0;
            state_d  = DONE;
          end else begin
            byte_d  = byte_q + 9'd1;
            state_d = WR_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Addresses track the counter; byte_d is zero on the way into DONE.
    sd_buff_addr_d = byte_d;
    store_addr_d   = {lba_d, byte_d};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      lba_q          <= '0;
      is_rd_q        <= 1'b0;
      byte_q         <= 9'd0;
      dly_q          <= 4'd0;
      sd_ack_q       <= 1'b0;
      sd_buff_addr_q <= 9'd0;
      sd_buff_dout_q <= 8'd0;
      sd_buff_wr_q   <= 1'b0;
      store_rd_q     <= 1'b0;
      store_wr_q     <= 1'b0;
      store_din_q    <= 8'd0;
      store_addr_q   <= '0;
    end else begin
      state_q        <= state_d;
      lba_q          <= lba_d;
      is_rd_q        <= is_rd_d;
      byte_q         <= byte_d;
      dly_q          <= dly_d;
      sd_ack_q       <= sd_ack_d;
      sd_buff_addr_q <= sd_buff_addr_d;
      sd_buff_dout_q <= sd_buff_dout_d;
      sd_buff_wr_q   <= sd_buff_wr_d;
      store_rd_q     <= store_rd_d;
      store_wr_q     <= store_wr_d;
      store_din_q    <= store_din_d;
      store_addr_q   <= store_addr_d;
    end
  end

  assign sd_ack       = sd_ack_q;
  assign sd_buff_addr = sd_buff_addr_q;
  assign sd_buff_dout = sd_buff_dout_q;
  assign sd_buff_wr   = sd_buff_wr_q;
  assign store_addr   = store_addr_q;
  assign store_rd     = store_rd_q;
  assign store_wr     = store_wr_q;
  assign store_din    = store_din_q;

endmodule

// File: tb/tb_sd_blk_resp.sv
`timescale 1ns/1ps
// Bench for sd_blk_resp: per-block event queues derived from the block rules, checked every cycle,
// plus directed timing and literal expectations.
module tb_sd_blk_resp;
  localparam int LBA_W     = 8;
  localparam int ACK_DELAY = 4;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic [31:0]      sd_lba  = 32'd0;
  logic             sd_rd   = 1'b0;
  logic             sd_wr   = 1'b0;
  logic             sd_ack;
  logic [8:0]       sd_buff_addr;
  logic [7:0]       sd_buff_dout;
  logic             sd_buff_wr;
  logic [7:0]       sd_buff_din = 8'd0;
  logic [LBA_W+8:0] store_addr;
  logic             store_rd;
  logic             store_wr;
  logic [7:0]       store_din;
  logic [7:0]       store_dout;
  logic             store_ready = 1'b0;

  sd_blk_resp #(.LBA_W(LBA_W), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .store_addr(store_addr),
    .store_rd(store_rd), .store_wr(store_wr), .store_din(store_din),
    .store_dout(store_dout), .store_ready(store_ready)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // Backing store content: byte index xor block number.
  assign store_dout = store_addr[7:0] ^ store_addr[16:9];

  logic [7:0] ram [512];
  initial forever begin
    @(posedge clk_sys);
    sd_buff_din <= ram[sd_buff_addr];
  end

  int rdy_mode = 0;
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      store_ready = (rdy_mode == 0) ? 1'b1 : (rc % 7 == 0);
      rc++;
    end
  end

  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [16:0] addr; logic [7:0] dat; } ev_t;
  ev_t exp_buff[$];
  ev_t exp_rd[$];
  ev_t exp_st[$];

  function automatic void model_read(input logic [31:0] lba);
    ev_t e;
    for (int i = 0; i < 512; i++) begin
      e.addr = {lba[7:0], 9'(i)};
      e.dat  = 8'(i) ^ lba[7:0];
      exp_rd.push_back(e);
      e.addr = 17'(i);
      exp_buff.push_back(e);
    end
  endfunction

  function automatic void model_write(input logic [31:0] lba);
    ev_t e;
    for (int i = 0; i < 512; i++) begin
      e.addr = {lba[7:0], 9'(i)};
      e.dat  = ram[i];
      exp_st.push_back(e);
    end
  endfunction

  int n_bwr = 0, n_stwr = 0, n_rdacc = 0;
  logic        prev_rd, prev_wr, prev_rdy, prev_bwr;
  logic [16:0] prev_addr;
  logic [7:0]  prev_din;
  logic [16:0] first_rd_addr, last_rd_addr, last_st_addr;
  logic [8:0]  last_b_addr;
  logic [7:0]  first_b_dat, last_b_dat, last_st_din;

  initial begin
    ev_t e;
    prev_rd = 0; prev_wr = 0; prev_rdy = 0; prev_bwr = 0; prev_addr = 0; prev_din = 0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_rd = 0; prev_wr = 0; prev_rdy = 0; prev_bwr = 0;
      end else begin
        chk("rd_wr_exclusive", 32'(store_rd & store_wr), 0);
        if (sd_buff_wr) begin
          chk("buff_wr_one_cycle", 32'(prev_bwr), 0);
          chk("buff_wr_pending", 32'(exp_buff.size() > 0), 1);
          if (exp_buff.size() > 0) begin
            e = exp_buff.pop_front();
            chk("buff_addr", 32'(sd_buff_addr), 32'(e.addr));
            chk("buff_data", 32'(sd_buff_dout), 32'(e.dat));
          end
          if (n_bwr == 0) first_b_dat = sd_buff_dout;
          last_b_addr = sd_buff_addr;
          last_b_dat  = sd_buff_dout;
          n_bwr++;
        end
        if (store_rd) begin
          if (prev_rd && !prev_rdy) chk("rd_addr_stable", 32'(store_addr), 32'(prev_addr));
          if (store_ready) begin
            chk("rd_acc_pending", 32'(exp_rd.size() > 0), 1);
            if (exp_rd.size() > 0) begin
              e = exp_rd.pop_front();
              chk("store_rd_addr", 32'(store_addr), 32'(e.addr));
            end
            if (n_rdacc == 0) first_rd_addr = store_addr;
            last_rd_addr = store_addr;
            n_rdacc++;
          end
        end
        if (store_wr) begin
          if (prev_wr && !prev_rdy) begin
            chk("wr_addr_stable", 32'(store_addr), 32'(prev_addr));
            chk("wr_din_stable", 32'(store_din), 32'(prev_din));
          end
          if (store_ready) begin
            chk("wr_acc_pending", 32'(exp_st.size() > 0), 1);
            if (exp_st.size() > 0) begin
              e = exp_st.pop_front();
              chk("store_wr_addr", 32'(store_addr), 32'(e.addr));
              chk("store_wr_data", 32'(store_din), 32'(e.dat));
            end
            last_st_addr = store_addr;
            last_st_din  = store_din;
            n_stwr++;
          end
        end
        prev_rd = store_rd; prev_wr = store_wr; prev_rdy = store_ready;
        prev_bwr = sd_buff_wr; prev_addr = store_addr; prev_din = store_din;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ack"}, 32'(sd_ack), 0);
    chk({tag, "_buff_wr"}, 32'(sd_buff_wr), 0);
    chk({tag, "_store_rd"}, 32'(store_rd), 0);
    chk({tag, "_store_wr"}, 32'(store_wr), 0);
    chk({tag, "_buff_addr"}, 32'(sd_buff_addr), 0);
    chk({tag, "_buff_dout"}, 32'(sd_buff_dout), 0);
    chk({tag, "_store_din"}, 32'(store_din), 0);
    chk({tag, "_store_addr"}, 32'(store_addr), 0);
  endtask

  task automatic start_req(input logic [31:0] lba, input logic rd, input logic wr);
    @(negedge clk_sys);
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    @(negedge clk_sys);
    sd_rd = 0; sd_wr = 0;
  endtask

  // One isolated transfer; exp_high < 0 skips the ack-width check (backpressured runs).
  task automatic run_xfer(input string tag, input logic [31:0] lba, input logic rd,
                          input logic wr, input int exp_high);
    int n, h, b0, s0;
    b0 = n_bwr; s0 = n_stwr;
    start_req(lba, rd, wr);
    n = 1;
    while (!sd_ack && n < 100) begin @(negedge clk_sys); n++; end
    chk({tag, "_ack_latency"}, 32'(n), 32'(ACK_DELAY + 1));
    h = 0;
    while (sd_ack && h < 8000) begin @(negedge clk_sys); h++; end
    if (exp_high >= 0) chk({tag, "_ack_high_cycles"}, 32'(h), 32'(exp_high));
    chk({tag, "_done_addr"}, 32'(sd_buff_addr), 0);
    repeat (2) @(negedge clk_sys);
    chk({tag, "_buff_wr_count"}, 32'(n_bwr - b0), rd ? 32'd512 : 32'd0);
    chk({tag, "_store_wr_count"}, 32'(n_stwr - s0), rd ? 32'd0 : 32'd512);
    chk({tag, "_queues_drained"}, 32'(exp_buff.size() + exp_rd.size() + exp_st.size()), 0);
  endtask

  initial begin
    int w, base, h, gap, b0;
    for (int i = 0; i < 512; i++) ram[i] = 8'(i);
    repeat (3) @(negedge clk_sys);
    check_outputs_zero("reset");
    reset = 0;

    // Plain read of block 5, store always ready.
    model_read(32'h05);
    run_xfer("rd05", 32'h05, 1'b1, 1'b0, 1024);
    chk("rd05_first_store_addr", 32'(first_rd_addr), 32'h0A00);
    chk("rd05_last_store_addr", 32'(last_rd_addr), 32'h0BFF);
    chk("rd05_first_data", 32'(first_b_dat), 32'h05);
    chk("rd05_last_buff_addr", 32'(last_b_addr), 32'd511);
    chk("rd05_last_data", 32'(last_b_dat), 32'hFA);

    // Plain write of block 3.
    model_write(32'h03);
    run_xfer("wr03", 32'h03, 1'b0, 1'b1, 1536);
    chk("wr03_last_store_addr", 32'(last_st_addr), 32'h07FF);
    chk("wr03_last_din", 32'(last_st_din), 32'hFF);

    // Read with the store accepting once every 7 cycles.
    rdy_mode = 1;
    model_read(32'h2A);
    run_xfer("rd_bp", 32'h2A, 1'b1, 1'b0, -1);

    // Both requests together: read wins, no write strobes expected.
    rdy_mode = 0;
    model_read(32'h11);
    run_xfer("rdwr", 32'h11, 1'b1, 1'b1, 1024);

    // Reset in the middle of a backpressured write, at byte 200.
    rdy_mode = 1;
    model_write(32'h07);
    base = n_stwr;
    start_req(32'h07, 1'b0, 1'b1);
    w = 0;
    while ((n_stwr - base) < 200 && w < 20000) begin @(negedge clk_sys); w++; end
    chk("rst_at_byte200", 32'(n_stwr - base), 32'd200);
    #2 reset = 1;
    #1 check_outputs_zero("midreset");
    exp_st.delete();
    repeat (2) @(negedge clk_sys);
    #2 reset = 0;
    rdy_mode = 0;
    model_write(32'h09);
    run_xfer("wr_after_rst", 32'h09, 1'b0, 1'b1, 1536);

    // Chained reads: next request raised on each sd_ack fall, lba crossing 0xFF.
    b0 = n_bwr;
    for (int k = 0; k < 64; k++) model_read(32'hF0 + 32'(k));
    @(negedge clk_sys);
    sd_lba = 32'hF0; sd_rd = 1;
    w = 0;
    while (!sd_ack && w < 50) begin @(negedge clk_sys); w++; end
    sd_rd = 0;
    for (int k = 0; k < 64; k++) begin
      h = 0;
      while (sd_ack && h < 5000) begin @(negedge clk_sys); h++; end
      chk("chain_ack_high", 32'(h), 32'd1024);
      if (k < 63) begin
        sd_lba = 32'hF0 + 32'(k + 1); sd_rd = 1;
        gap = 1;
        @(negedge clk_sys);
        while (!sd_ack && gap < 50) begin gap++; @(negedge clk_sys); end
        chk("chain_ack_gap", 32'(gap), 32'(ACK_DELAY + 2));
        sd_rd = 0;
      end
    end
    repeat (2) @(negedge clk_sys);
    chk("chain_buff_wr_count", 32'(n_bwr - b0), 32'd32768);
    chk("chain_queues_drained", 32'(exp_buff.size() + exp_rd.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
